// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO: default sizing,
// address/count width derivation and the per-cycle operation encoding.
package fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    // Per-cycle accepted operation, encoded as {write_accepted, read_accepted}.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

    // Ceiling log2, usable in parameter expressions (clog2(1) = 0).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // True when value is a non-zero power of two.
    function automatic bit is_pow2(input int value);
        return (value >= 1) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port DEPTH x WIDTH memory: synchronous write port and a
// registered read port. The read register is the FIFO's Data_out, so it is
// cleared by reset and holds its value when no read is enabled.
module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Write port: contents are never cleared, only overwritten.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    // Read port: read-before-write, so a same-address write in the same
    // cycle (full FIFO, simultaneous read and write) returns the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_buffer_param.sv
// Parametrised synchronous FIFO. Holds the read/write pointers, occupancy
// count and sticky error flags; storage and the registered read data live
// in fifo_ram. Status flags are decoded straight from the registered count.
module fifo_buffer_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     write_to_stack,
    input  logic                     read_from_stack,
    input  logic [WIDTH-1:0]         Data_in,
    output logic [WIDTH-1:0]         Data_out,
    output logic                     data_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [clog2(DEPTH):0]    count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT    = CW'(AE_LEVEL);

    // Reject illegal configurations at elaboration time.
    generate
        if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_err_depth
            $error("fifo_buffer_param: DEPTH must be a power of two and at least 2");
        end
        if (WIDTH < 1) begin : g_err_width
            $error("fifo_buffer_param: WIDTH must be at least 1");
        end
        if (AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_err_levels
            $error("fifo_buffer_param: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
        end
    endgenerate

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          data_valid_q;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic     full_w;
    logic     empty_w;
    logic     wr_ok;
    logic     rd_ok;
    fifo_op_e op_sel;

    assign full_w  = (count_q == DEPTH_CNT);
    assign empty_w = (count_q == '0);

    // Accept decisions on pre-edge state. A write to a full FIFO is allowed
    // only alongside a read, which frees the slot being overwritten. A read
    // never falls through from a same-cycle write into an empty FIFO.
    // Requests coincident with reset are ignored.
    assign wr_ok  = !rst && write_to_stack && (!full_w || read_from_stack);
    assign rd_ok  = !rst && read_from_stack && !empty_w;
    assign op_sel = fifo_op_e'({wr_ok, rd_ok});

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        unique case (op_sel)
            OP_WRITE: count_d = count_q + CW'(1);
            OP_READ:  count_d = count_q - CW'(1);
            default:  count_d = count_q;
        endcase

        if (write_to_stack && !wr_ok) begin
            overflow_d = 1'b1;
        end
        if (read_from_stack && !rd_ok) begin
            underflow_d = 1'b1;
        end
    end

    // Control state registers; reset discards all stored data.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            data_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            data_valid_q <= rd_ok;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_ok),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (Data_in),
        .rd_en_i   (rd_ok),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (Data_out)
    );

    assign data_valid   = data_valid_q;
    assign count        = count_q;
    assign full         = full_w;
    assign empty        = empty_w;
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
